nec_prefetch: RTL and testbench

Instruction prefetch queue and code-fetch sequencer for the NEC core. Issues word or byte code fetches on the PS segment and stores the returned bytes in an 8-byte circular buffer indexed by address bits [2:0]. Presents the buffer and the count of valid bytes ahead of the decoder's `pc` directly to `nec_decode` as `ipq` / `ipq_len`. Flushes and retargets on `set_pc`, and stalls new fetches on `block_prefetch`.

---
 rtl/nec_prefetch_pkg.sv | 13 +
 rtl/nec_prefetch.sv | 88 ++++++++
 tb/tb_nec_prefetch.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nec_prefetch_pkg.sv
// Shared types and constants for the NEC core front end (prefetch queue and decoder).
package nec_prefetch_pkg;

  localparam int IPQ_DEPTH = 8;

  typedef logic [1:0] prefetch_state_e;

  localparam prefetch_state_e ST_IDLE    = 2'd0;
  localparam prefetch_state_e ST_REQ     = 2'd1;
  localparam prefetch_state_e ST_WAIT    = 2'd2;
  localparam prefetch_state_e ST_DISCARD = 2'd3;

endpackage

// File: rtl/nec_prefetch.sv
// Instruction prefetch queue: fetches code bytes on the PS segment into an
// 8-byte circular buffer indexed by address bits [2:0], ahead of the decoder pc.
module nec_prefetch
  import nec_prefetch_pkg::*;
#(
  parameter int FETCH_SPACE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1,
  input  logic        ce_2,
  input  logic [15:0] decode_pc,
  input  logic        set_pc,
  input  logic [15:0] new_pc,
  input  logic        block_prefetch,
  input  logic [15:0] ps_seg,
  output logic        bus_req,
  output logic [19:0] bus_addr,
  output logic        bus_byte,
  input  logic        bus_ack,
  input  logic        bus_ready,
  input  logic [15:0] bus_data,
  output logic [3:0]  ipq_len,
  output logic [7:0]  ipq [0:IPQ_DEPTH-1]
);

  prefetch_state_e state;
  logic [15:0]     fetch_pc;
  logic [15:0]     pc_diff;
  logic [3:0]      free_bytes;
  logic [3:0]      fetch_size;
  logic [3:0]      need_bytes;
  logic            start_ok;
  logic            enable;
  logic [2:0]      idx_lo;
  logic [2:0]      idx_hi;

  assign enable = ce_1 | ce_2;

  // The fetch policy keeps fetch_pc at most 8 bytes ahead, so the low nibble suffices.
  assign pc_diff    = fetch_pc - decode_pc;
  assign ipq_len    = pc_diff[3:0];
  assign free_bytes = 4'(IPQ_DEPTH) - ipq_len;

  assign fetch_size = fetch_pc[0] ? 4'd1 : 4'd2;
  assign need_bytes = (4'(FETCH_SPACE) > fetch_size) ? 4'(FETCH_SPACE) : fetch_size;
  assign start_ok   = !block_prefetch && (free_bytes >= need_bytes);

  assign bus_req  = (state == ST_REQ);
  assign bus_addr = {ps_seg, 4'b0000} + {4'b0000, fetch_pc};
  assign bus_byte = fetch_pc[0];

  assign idx_lo = fetch_pc[2:0];
  assign idx_hi = idx_lo + 3'd1;

  // NOTE: the byte store is reset too, so the decoder never sees X bytes after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      fetch_pc <= 16'h0000;
      for (int i = 0; i < IPQ_DEPTH; i++) ipq[i] <= 8'h00;
    end else if (enable) begin
      if (set_pc) begin
        // Redirect wins; an already-acked fetch must still be drained in DISCARD.
        fetch_pc <= new_pc;
        case (state)
          ST_WAIT, ST_DISCARD: state <= bus_ready ? ST_IDLE : ST_DISCARD;
          default:             state <= ST_IDLE;
        endcase
      end else begin
        case (state)
          ST_IDLE: if (start_ok) state <= ST_REQ;
          ST_REQ:  if (bus_ack) state <= ST_WAIT;
          ST_WAIT: begin
            if (bus_ready) begin
              ipq[idx_lo] <= bus_data[7:0];
              if (!fetch_pc[0]) ipq[idx_hi] <= bus_data[15:8];
              fetch_pc <= fetch_pc + {12'h000, fetch_size};
              state    <= ST_IDLE;
            end
          end
          default: if (bus_ready) state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nec_prefetch.sv
// Directed self-checking bench for nec_prefetch with a hand-driven code-fetch bus.
module tb_nec_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_1, ce_2;
  logic [15:0] decode_pc;
  logic        set_pc;
  logic [15:0] new_pc;
  logic        block_prefetch;
  logic [15:0] ps_seg;
  logic        bus_req;
  logic [19:0] bus_addr;
  logic        bus_byte;
  logic        bus_ack;
  logic        bus_ready;
  logic [15:0] bus_data;
  logic [3:0]  ipq_len;
  logic [7:0]  ipq [0:7];

  int vectors = 0;
  int miscompares = 0;

  nec_prefetch #(.FETCH_SPACE(2)) dut (
    .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2),
    .decode_pc(decode_pc), .set_pc(set_pc), .new_pc(new_pc),
    .block_prefetch(block_prefetch), .ps_seg(ps_seg),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_byte(bus_byte),
    .bus_ack(bus_ack), .bus_ready(bus_ready), .bus_data(bus_data),
    .ipq_len(ipq_len), .ipq(ipq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Wait (bounded) for a request, then check its address and size.
  task automatic expect_req(input string tag, input logic [19:0] addr, input logic is_byte);
    for (int i = 0; i < 20 && !bus_req; i++) @(negedge clk);
    check({tag, "_req"}, 32'(bus_req), 32'd1);
    check({tag, "_addr"}, 32'(bus_addr), 32'(addr));
    check({tag, "_byte"}, 32'(bus_byte), 32'(is_byte));
  endtask

  // Ack for one edge, then return data on the following edge.
  task automatic serve(input logic [15:0] data);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_ready = 1'b1;
    bus_data  = data;
    @(negedge clk);
    bus_ready = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] pc);
    set_pc    = 1'b1;
    new_pc    = pc;
    decode_pc = pc;
    @(negedge clk);
    set_pc = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ce_1 = 1'b0; ce_2 = 1'b0; decode_pc = 16'h0000;
    set_pc = 1'b0; new_pc = 16'h0000; block_prefetch = 1'b0; ps_seg = 16'h1000;
    bus_ack = 1'b0; bus_ready = 1'b0; bus_data = 16'h0000;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_addr", 32'(bus_addr), 32'h10000);
    check("rst_byte", 32'(bus_byte), 32'd0);
    check("rst_len", 32'(ipq_len), 32'd0);
    check("rst_ipq3", 32'(ipq[3]), 32'h00);

    // Without a phase enable nothing advances
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("ce_off_req", 32'(bus_req), 32'd0);

    // Fill the queue with decode_pc held at 0 (ce_2 alone enables)
    ce_2 = 1'b1;
    expect_req("fill0", 20'h10000, 1'b0); serve(16'h11A0);
    check("fill0_len", 32'(ipq_len), 32'd2);
    expect_req("fill2", 20'h10002, 1'b0); serve(16'h3322);
    expect_req("fill4", 20'h10004, 1'b0); serve(16'h5544);
    expect_req("fill6", 20'h10006, 1'b0); serve(16'h7766);
    check("fill_len8", 32'(ipq_len), 32'd8);
    repeat (4) @(negedge clk);
    check("full_noreq", 32'(bus_req), 32'd0);
    check("fill_ipq0", 32'(ipq[0]), 32'hA0);
    check("fill_ipq5", 32'(ipq[5]), 32'h55);
    check("fill_ipq7", 32'(ipq[7]), 32'h77);

    // Redirect to an odd address: byte fetch first, then words
    ce_1 = 1'b1; ce_2 = 1'b0;
    redirect(16'h0003);
    check("odd_len0", 32'(ipq_len), 32'd0);
    expect_req("odd3", 20'h10003, 1'b1); serve(16'hAB5A);
    check("odd_ipq3", 32'(ipq[3]), 32'h5A);
    check("odd_ipq4_kept", 32'(ipq[4]), 32'h44);
    check("odd_len1", 32'(ipq_len), 32'd1);
    expect_req("odd4", 20'h10004, 1'b0); serve(16'h2211);
    expect_req("odd6", 20'h10006, 1'b0); serve(16'h4433);
    expect_req("odd8", 20'h10008, 1'b0); serve(16'h6655);
    check("odd_len7", 32'(ipq_len), 32'd7);
    repeat (3) @(negedge clk);
    check("odd_noreq", 32'(bus_req), 32'd0);
    check("odd_ipq0", 32'(ipq[0]), 32'h55);
    check("odd_ipq2_kept", 32'(ipq[2]), 32'h22);
    check("odd_ipq5", 32'(ipq[5]), 32'h22);

    // set_pc during WAIT: returned data is dropped
    redirect(16'h0100);
    expect_req("dwait", 20'h10100, 1'b0);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    redirect(16'h0200);
    check("dwait_len0", 32'(ipq_len), 32'd0);
    check("dwait_noreq", 32'(bus_req), 32'd0);
    bus_ready = 1'b1; bus_data = 16'hDEAD;
    @(negedge clk);
    bus_ready = 1'b0;
    check("dwait_len_after", 32'(ipq_len), 32'd0);
    check("dwait_ipq0", 32'(ipq[0]), 32'h55);
    check("dwait_ipq1", 32'(ipq[1]), 32'h66);
    expect_req("dwait_next", 20'h10200, 1'b0); serve(16'hBEEF);
    check("dwait_ipq0_new", 32'(ipq[0]), 32'hEF);
    check("dwait_len2", 32'(ipq_len), 32'd2);

    // set_pc coincident with bus_ready
    expect_req("coin", 20'h10202, 1'b0);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0; bus_ready = 1'b1; bus_data = 16'h9999;
    redirect(16'h0300);
    bus_ready = 1'b0;
    check("coin_len0", 32'(ipq_len), 32'd0);
    check("coin_ipq2", 32'(ipq[2]), 32'h22);
    check("coin_idle", 32'(bus_req), 32'd0);
    @(negedge clk);
    check("coin_req_next", 32'(bus_req), 32'd1);
    check("coin_addr_next", 32'(bus_addr), 32'h10300);
    serve(16'h0C0B);
    check("coin_ipq0", 32'(ipq[0]), 32'h0B);

    // block_prefetch: in-flight cycle completes, no new request at ipq_len 4
    expect_req("blk", 20'h10302, 1'b0);
    block_prefetch = 1'b1;
    serve(16'h0E0D);
    check("blk_len4", 32'(ipq_len), 32'd4);
    check("blk_ipq3", 32'(ipq[3]), 32'h0E);
    repeat (5) @(negedge clk);
    check("blk_noreq", 32'(bus_req), 32'd0);
    block_prefetch = 1'b0;
    @(negedge clk);
    check("blk_release_req", 32'(bus_req), 32'd1);
    check("blk_release_addr", 32'(bus_addr), 32'h10304);
    serve(16'h1F1E);
    check("blk_len6", 32'(ipq_len), 32'd6);

    // Wrap across 0xFFFF -> 0x0000
    redirect(16'hFFFE);
    check("wrap_len0", 32'(ipq_len), 32'd0);
    expect_req("wrapFFFE", 20'h1FFFE, 1'b0); serve(16'h7766);
    expect_req("wrap0000", 20'h10000, 1'b0);
    block_prefetch = 1'b1;
    serve(16'h9988);
    check("wrap_len4", 32'(ipq_len), 32'd4);
    check("wrap_ipq6", 32'(ipq[6]), 32'h66);
    check("wrap_ipq7", 32'(ipq[7]), 32'h77);
    check("wrap_ipq0", 32'(ipq[0]), 32'h88);
    check("wrap_ipq1", 32'(ipq[1]), 32'h99);

    // Decoder consumption frees space
    decode_pc = 16'h0000;
    @(negedge clk);
    check("consume_len2", 32'(ipq_len), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
